// File: rtl/ddr2_controller_dmaster_pkt_arbiter.sv
// Packet-atomic two-requester arbiter merging Avalon-ST streams onto one channelized source.
// Define DMASTER_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module ddr2_controller_dmaster_pkt_arbiter #(
    parameter int CHANNEL_W = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 a_valid,
    output logic                 a_ready,
    input  logic [7:0]           a_data,
    input  logic                 a_startofpacket,
    input  logic                 a_endofpacket,
    input  logic                 b_valid,
    output logic                 b_ready,
    input  logic [7:0]           b_data,
    input  logic                 b_startofpacket,
    input  logic                 b_endofpacket,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           out_data,
    output logic [CHANNEL_W-1:0] out_channel,
    output logic                 out_startofpacket,
    output logic                 out_endofpacket,
    output logic                 err_nosop
);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t     state, state_next;
    logic       grant, grant_next;
    logic       last_grant, last_grant_next;
    logic       sop_a, sop_b;
    logic       ready_g, accept, nosop;
    logic       sel_valid, sel_sop, sel_eop;
    logic [7:0] sel_data;

    assign sop_a     = a_valid && a_startofpacket;
    assign sop_b     = b_valid && b_startofpacket;
    assign sel_valid = grant ? b_valid         : a_valid;
    assign sel_data  = grant ? b_data          : a_data;
    assign sel_sop   = grant ? b_startofpacket : a_startofpacket;
    assign sel_eop   = grant ? b_endofpacket   : a_endofpacket;
    assign ready_g   = !out_valid || out_ready;

    always_comb begin
        state_next      = state;
        grant_next      = grant;
        last_grant_next = last_grant;
        a_ready         = 1'b0;
        b_ready         = 1'b0;
        accept          = 1'b0;
        nosop           = 1'b0;
        case (state)
            IDLE: begin
                // Beats outside a packet are swallowed so a stray source cannot stall the arbiter.
                a_ready = a_valid && !a_startofpacket;
                b_ready = b_valid && !b_startofpacket;
                nosop   = a_ready || b_ready;
                if (sop_a && sop_b) begin
`ifdef DMASTER_ARB_FIXED_PRIO_EN
                    grant_next = 1'b0;
`else
                    grant_next = !last_grant;
`endif
                    state_next = LOCK;
                end else if (sop_a) begin
                    grant_next = 1'b0;
                    state_next = LOCK;
                end else if (sop_b) begin
                    grant_next = 1'b1;
                    state_next = LOCK;
                end
            end
            LOCK: begin
                if (grant) begin
                    b_ready = ready_g;
                end else begin
                    a_ready = ready_g;
                end
                accept = sel_valid && ready_g;
                if (accept && sel_eop) begin
                    state_next      = IDLE;
                    last_grant_next = grant;
                end
            end
            default: state_next = IDLE;
        endcase
        if (!reset_n) begin
            a_ready = 1'b0;
            b_ready = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            grant             <= 1'b0;
            last_grant        <= 1'b1;
            out_valid         <= 1'b0;
            out_data          <= '0;
            out_channel       <= '0;
            out_startofpacket <= 1'b0;
            out_endofpacket   <= 1'b0;
            err_nosop         <= 1'b0;
        end else begin
            state      <= state_next;
            grant      <= grant_next;
            last_grant <= last_grant_next;
            if (accept) begin
                out_valid         <= 1'b1;
                out_data          <= sel_data;
                out_channel       <= {{(CHANNEL_W-1){1'b0}}, grant};
                out_startofpacket <= sel_sop;
                out_endofpacket   <= sel_eop;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (nosop) begin
                err_nosop <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ddr2_controller_dmaster_pkt_arbiter.sv
// Bench for the packet arbiter: packet-level arbitration model plus directed literal checks.
// Honours DMASTER_ARB_FIXED_PRIO_EN for the expected grant order.
module tb_ddr2_controller_dmaster_pkt_arbiter;

    localparam int CW = 8;

    typedef struct packed {
        logic [7:0] data;
        logic       sop;
        logic       eop;
    } beat_t;

    typedef struct packed {
        logic [7:0] chan;
        logic [7:0] data;
        logic       sop;
        logic       eop;
    } obeat_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          a_valid, a_ready, a_startofpacket, a_endofpacket;
    logic          b_valid, b_ready, b_startofpacket, b_endofpacket;
    logic [7:0]    a_data, b_data, out_data;
    logic          out_valid, out_ready, out_startofpacket, out_endofpacket;
    logic [CW-1:0] out_channel;
    logic          err_nosop;

    beat_t  src_a[$];
    beat_t  src_b[$];
    obeat_t exp_q[$];
    obeat_t out_log[$];
    int     n_cmp = 0;
    int     n_err = 0;
    int     cyc = 0;
    bit     model_last = 1'b1;

    ddr2_controller_dmaster_pkt_arbiter #(.CHANNEL_W(CW)) dut (
        .clk(clk), .reset_n(reset_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .a_startofpacket(a_startofpacket), .a_endofpacket(a_endofpacket),
        .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
        .b_startofpacket(b_startofpacket), .b_endofpacket(b_endofpacket),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_channel(out_channel), .out_startofpacket(out_startofpacket),
        .out_endofpacket(out_endofpacket), .err_nosop(err_nosop)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Source drivers: present queue heads, pop on a handshake sampled at the preceding negedge.
    initial begin
        bit acc_a, acc_b;
        a_valid = 1'b0; a_data = '0; a_startofpacket = 1'b0; a_endofpacket = 1'b0;
        b_valid = 1'b0; b_data = '0; b_startofpacket = 1'b0; b_endofpacket = 1'b0;
        forever begin
            @(negedge clk);
            acc_a = a_valid && a_ready;
            acc_b = b_valid && b_ready;
            @(posedge clk);
            #1;
            if (acc_a && src_a.size() > 0) void'(src_a.pop_front());
            if (acc_b && src_b.size() > 0) void'(src_b.pop_front());
            if (src_a.size() > 0) begin
                a_valid = 1'b1;
                {a_data, a_startofpacket, a_endofpacket} = src_a[0];
            end else begin
                a_valid = 1'b0; a_data = '0; a_startofpacket = 1'b0; a_endofpacket = 1'b0;
            end
            if (src_b.size() > 0) begin
                b_valid = 1'b1;
                {b_data, b_startofpacket, b_endofpacket} = src_b[0];
            end else begin
                b_valid = 1'b0; b_data = '0; b_startofpacket = 1'b0; b_endofpacket = 1'b0;
            end
        end
    end

    // Every completed output transfer is checked against the model's expected stream.
    always @(negedge clk) begin
        obeat_t got, want;
        if (reset_n && out_valid && out_ready) begin
            got = {out_channel, out_data, out_startofpacket, out_endofpacket};
            out_log.push_back(got);
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("[TB] FAIL out_beat: got ch=%0d data=%02h sop=%0b eop=%0b, required no beat",
                         got.chan, got.data, got.sop, got.eop);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    n_err++;
                    $display("[TB] FAIL out_beat: got ch=%0d data=%02h sop=%0b eop=%0b, required ch=%0d data=%02h sop=%0b eop=%0b",
                             got.chan, got.data, got.sop, got.eop, want.chan, want.data, want.sop, want.eop);
                end
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] req);
        n_cmp++;
        if (got !== req) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    task automatic push_pkt(input bit src, input logic [7:0] d0, input int n);
        beat_t bt;
        for (int i = 0; i < n; i++) begin
            bt.data = d0 + 8'(i);
            bt.sop  = (i == 0);
            bt.eop  = (i == n - 1);
            if (src) src_b.push_back(bt);
            else     src_a.push_back(bt);
        end
    endtask

    // Packet-level arbitration: whole packets are granted in turn from the queued sources.
    task automatic model_schedule();
        beat_t qa[$];
        beat_t qb[$];
        beat_t bt;
        bit    pick;
        qa = src_a;
        qb = src_b;
        while (qa.size() > 0 || qb.size() > 0) begin
            if (qa.size() > 0 && qb.size() > 0) begin
`ifdef DMASTER_ARB_FIXED_PRIO_EN
                pick = 1'b0;
`else
                pick = !model_last;
`endif
            end else begin
                pick = (qa.size() == 0);
            end
            do begin
                bt = pick ? qb.pop_front() : qa.pop_front();
                exp_q.push_back({8'(pick), bt.data, bt.sop, bt.eop});
            end while (!bt.eop && (pick ? qb.size() : qa.size()) > 0);
            model_last = pick;
        end
    endtask

    task automatic apply_stimulus_drain(input int max_cycles);
        bit done;
        done = 1'b0;
        for (int i = 0; i < max_cycles && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && src_a.size() == 0 && src_b.size() == 0 && !out_valid) done = 1'b1;
        end
        check_output("drain", 32'(done), 32'd1);
    endtask

    task automatic apply_stimulus_reset();
        reset_n = 1'b0;
        src_a.delete();
        src_b.delete();
        exp_q.delete();
        model_last = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t_a, t_o, nosop_cycles;
        bit hit;
        logic [3:0] chan_seq;
        out_ready = 1'b1;
        reset_n   = 1'b0;
        // Reset state, with a stray beat presented so ready gating is observable.
        src_a.push_back({8'h99, 1'b0, 1'b0});
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("rst_out_valid", 32'(out_valid), 32'd0);
        check_output("rst_out_data", 32'(out_data), 32'd0);
        check_output("rst_out_channel", 32'(out_channel), 32'd0);
        check_output("rst_out_sop_eop", {30'd0, out_startofpacket, out_endofpacket}, 32'd0);
        check_output("rst_err_nosop", 32'(err_nosop), 32'd0);
        check_output("rst_a_valid_seen", 32'(a_valid), 32'd1);
        check_output("rst_a_ready", 32'(a_ready), 32'd0);
        check_output("rst_b_ready", 32'(b_ready), 32'd0);
        src_a.delete();
        @(negedge clk);
        reset_n = 1'b1;

        // Single three-beat packet on a, latency from a_valid to first out_valid.
        @(negedge clk);
        out_log.delete();
        push_pkt(1'b0, 8'h11, 1);
        push_pkt(1'b0, 8'h22, 1);
        src_a[0].eop = 1'b0;
        src_a[1].sop = 1'b0; src_a[1].eop = 1'b0;
        src_a.push_back({8'h33, 1'b0, 1'b1});
        model_schedule();
        t_a = -1; t_o = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (a_valid && t_a < 0) t_a = cyc;
            if (out_valid && t_o < 0) t_o = cyc;
        end
        check_output("latency", 32'(t_o - t_a), 32'd2);
        apply_stimulus_drain(50);
        check_output("pkt1_count", 32'(out_log.size()), 32'd3);
        if (out_log.size() == 3) begin
            check_output("pkt1_beat0", 32'(out_log[0]), {14'd0, 8'h00, 8'h11, 1'b1, 1'b0});
            check_output("pkt1_beat1", 32'(out_log[1]), {14'd0, 8'h00, 8'h22, 1'b0, 1'b0});
            check_output("pkt1_beat2", 32'(out_log[2]), {14'd0, 8'h00, 8'h33, 1'b0, 1'b1});
        end

        // Simultaneous SOP, two packets each side.
        apply_stimulus_reset();
        out_log.delete();
        push_pkt(1'b0, 8'hA1, 2);
        push_pkt(1'b0, 8'hA3, 2);
        push_pkt(1'b1, 8'hB1, 2);
        push_pkt(1'b1, 8'hB3, 2);
        model_schedule();
        apply_stimulus_drain(100);
        check_output("arb_count", 32'(out_log.size()), 32'd8);
        if (out_log.size() == 8) begin
            chan_seq = {out_log[0].chan[0], out_log[2].chan[0], out_log[4].chan[0], out_log[6].chan[0]};
`ifdef DMASTER_ARB_FIXED_PRIO_EN
            check_output("arb_chan_order", 32'(chan_seq), 32'b0011);
            check_output("arb_second_pkt", 32'(out_log[2].data), 32'hA3);
`else
            check_output("arb_chan_order", 32'(chan_seq), 32'b0101);
            check_output("arb_second_pkt", 32'(out_log[2].data), 32'hB1);
`endif
            check_output("arb_first_pkt", 32'(out_log[0].data), 32'hA1);
            for (int i = 0; i < 8; i += 2)
                check_output("arb_no_interleave", 32'(out_log[i+1].data), 32'(out_log[i].data + 8'd1));
        end

        // Backpressure for four cycles mid-packet.
        @(negedge clk);
        out_log.delete();
        push_pkt(1'b0, 8'h41, 4);
        model_schedule();
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge clk);
            if (out_valid && out_data == 8'h42) hit = 1'b1;
        end
        check_output("bp_reach_beat2", 32'(hit), 32'd1);
        @(posedge clk);
        #1 out_ready = 1'b0;
        check_output("bp_held_data", 32'(out_data), 32'h43);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_output("bp_data_stable", 32'(out_data), 32'h43);
            check_output("bp_valid_held", 32'(out_valid), 32'd1);
            check_output("bp_a_ready", 32'(a_ready), 32'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        apply_stimulus_drain(50);
        check_output("bp_count", 32'(out_log.size()), 32'd4);

        // Beat without SOP on b in IDLE is swallowed and flagged.
        @(negedge clk);
        out_log.delete();
        src_b.push_back({8'h5A, 1'b0, 1'b0});
        nosop_cycles = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (b_valid) begin
                nosop_cycles++;
                check_output("nosop_b_ready", 32'(b_ready), 32'd1);
            end
        end
        check_output("nosop_cycles", 32'(nosop_cycles), 32'd1);
        check_output("nosop_err", 32'(err_nosop), 32'd1);
        check_output("nosop_no_output", 32'(out_log.size()), 32'd0);
        // Single-beat packet afterwards; the flag must stay set.
        push_pkt(1'b0, 8'hC3, 1);
        model_schedule();
        apply_stimulus_drain(50);
        check_output("single_count", 32'(out_log.size()), 32'd1);
        if (out_log.size() == 1)
            check_output("single_beat", 32'(out_log[0]), {14'd0, 8'h00, 8'hC3, 1'b1, 1'b1});
        check_output("nosop_err_sticky", 32'(err_nosop), 32'd1);

        // Reset in the middle of a four-beat packet, then a clean packet from b.
        @(negedge clk);
        push_pkt(1'b0, 8'h61, 4);
        model_schedule();
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge clk);
            if (a_valid && a_ready && a_data == 8'h62) hit = 1'b1;
        end
        check_output("midrst_reach_beat2", 32'(hit), 32'd1);
        check_output("midrst_out_busy", 32'(out_valid), 32'd1);
        #2 reset_n = 1'b0;
        src_a.delete();
        src_b.delete();
        exp_q.delete();
        model_last = 1'b1;
        #1;
        check_output("midrst_out_valid", 32'(out_valid), 32'd0);
        check_output("midrst_err", 32'(err_nosop), 32'd0);
        check_output("midrst_a_ready", 32'(a_ready), 32'd0);
        out_log.delete();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        push_pkt(1'b1, 8'h71, 2);
        model_schedule();
        apply_stimulus_drain(50);
        check_output("postrst_count", 32'(out_log.size()), 32'd2);
        if (out_log.size() == 2)
            check_output("postrst_first", 32'(out_log[0]), {14'd0, 8'h01, 8'h71, 1'b1, 1'b0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
